// File: rtl/interface_input.sv
// Host-side command unpacker for the CORDIC core: buffers 32-bit command words in a
// two-entry FIFO, folds rotation angles into [-90, +90] degrees and flags the x negation.
module interface_input #(
    parameter int                     INPUT_WIDTH      = 16,
    parameter int                     INPUT_INT_WIDTH  = 7,
    parameter int                     INPUT_FRAC_WIDTH = 8,
    parameter int                     FLIP_FLAG_WIDTH  = 1,
    parameter logic [INPUT_WIDTH-1:0] ROT_X_INIT       = 16'h0100,
    parameter int                     FIFO_DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                in_interface,
    input  logic                       arctan_en_interface,
    input  logic                       valid_in_interface,
    output logic                       ready_in_interface,
    output logic [INPUT_WIDTH-1:0]     degree_in,
    output logic [INPUT_WIDTH-1:0]     x_in,
    output logic [INPUT_WIDTH-1:0]     y_in,
    output logic [FLIP_FLAG_WIDTH-1:0] flip_in,
    output logic                       arctan_en_in,
    output logic                       valid_in,
    input  logic                       core_ready
);

    // One guard bit above the operand so 180 - d cannot overflow before truncation.
    localparam int FOLD_WIDTH = INPUT_INT_WIDTH + INPUT_FRAC_WIDTH + 2;
    localparam int PTR_WIDTH  = 1;
    localparam int CNT_WIDTH  = 2;

    localparam logic signed [FOLD_WIDTH-1:0] HALF_TURN    = FOLD_WIDTH'(180 << INPUT_FRAC_WIDTH);
    localparam logic signed [FOLD_WIDTH-1:0] QUARTER_TURN = FOLD_WIDTH'(90 << INPUT_FRAC_WIDTH);

    typedef struct packed {
        logic [INPUT_WIDTH-1:0]     degree;
        logic [INPUT_WIDTH-1:0]     x;
        logic [INPUT_WIDTH-1:0]     y;
        logic [FLIP_FLAG_WIDTH-1:0] flip;
        logic                       arctan_en;
    } entry_t;

    entry_t                 fifo_mem_reg [FIFO_DEPTH];
    entry_t                 head_reg;
    entry_t                 head_next;
    entry_t                 conv_word;
    logic [PTR_WIDTH-1:0]   wr_ptr_reg;
    logic [PTR_WIDTH-1:0]   wr_ptr_next;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg;
    logic [PTR_WIDTH-1:0]   rd_ptr_next;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [CNT_WIDTH-1:0]   count_next;
    logic                   ready_reg;
    logic                   ready_next;
    logic                   valid_reg;
    logic                   valid_next;
    logic                   push;
    logic                   pop;
    logic [FIFO_DEPTH-1:0]  slot_we;
    logic signed [FOLD_WIDTH-1:0] angle_ext;

    // Word conversion: vectoring passes x/y straight through, rotation folds the angle.
    always_comb begin
        conv_word           = '0;
        angle_ext           = {{(FOLD_WIDTH-INPUT_WIDTH){in_interface[INPUT_WIDTH-1]}},
                               in_interface[INPUT_WIDTH-1:0]};
        conv_word.arctan_en = arctan_en_interface;
        if (arctan_en_interface) begin
            conv_word.x = in_interface[INPUT_WIDTH-1:0];
            conv_word.y = in_interface[2*INPUT_WIDTH-1:INPUT_WIDTH];
        end else begin
            conv_word.x = ROT_X_INIT;
            if (angle_ext > QUARTER_TURN) begin
                conv_word.degree = INPUT_WIDTH'(HALF_TURN - angle_ext);
                conv_word.flip   = FLIP_FLAG_WIDTH'(1);
            end else if (angle_ext < -QUARTER_TURN) begin
                conv_word.degree = INPUT_WIDTH'(-HALF_TURN - angle_ext);
                conv_word.flip   = FLIP_FLAG_WIDTH'(1);
            end else begin
                conv_word.degree = in_interface[INPUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        push        = valid_in_interface & ready_reg;
        pop         = valid_reg & core_ready;
        count_next  = count_reg + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
        wr_ptr_next = wr_ptr_reg + PTR_WIDTH'(push);
        rd_ptr_next = rd_ptr_reg + PTR_WIDTH'(pop);
        ready_next  = (count_next < CNT_WIDTH'(FIFO_DEPTH));
        valid_next  = (count_next != '0);
        // The new head is the incoming word whenever it lands in the slot being read next.
        head_next   = head_reg;
        if (valid_next) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                head_next = conv_word;
            end else begin
                head_next = fifo_mem_reg[rd_ptr_next];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push && (wr_ptr_reg == PTR_WIDTH'(gi));
        end
    endgenerate

    // Storage needs no reset: entries are only read once count says they are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_we[i]) begin
                fifo_mem_reg[i] <= conv_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            head_reg   <= '0;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            ready_reg  <= ready_next;
            valid_reg  <= valid_next;
            head_reg   <= head_next;
        end
    end

    assign ready_in_interface = ready_reg;
    assign valid_in           = valid_reg;
    assign degree_in          = head_reg.degree;
    assign x_in               = head_reg.x;
    assign y_in               = head_reg.y;
    assign flip_in            = head_reg.flip;
    assign arctan_en_in       = head_reg.arctan_en;

endmodule

// File: tb/tb_interface_input.sv
// Bench for interface_input: conversion vector table, hand-written FIFO corner sequences
// and a randomized run against a queue-based reference model.
module tb_interface_input;

    typedef struct packed {
        logic [15:0] degree;
        logic [15:0] x;
        logic [15:0] y;
        logic        flip;
        logic        arctan_en;
    } rec_t;

    typedef struct {
        logic [31:0] word;
        logic        arctan;
        rec_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_interface = '0;
    logic        arctan_en_interface = 1'b0;
    logic        valid_in_interface = 1'b0;
    logic        ready_in_interface;
    logic [15:0] degree_in;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [0:0]  flip_in;
    logic        arctan_en_in;
    logic        valid_in;
    logic        core_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    interface_input dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_interface        (in_interface),
        .arctan_en_interface (arctan_en_interface),
        .valid_in_interface  (valid_in_interface),
        .ready_in_interface  (ready_in_interface),
        .degree_in           (degree_in),
        .x_in                (x_in),
        .y_in                (y_in),
        .flip_in             (flip_in),
        .arctan_en_in        (arctan_en_in),
        .valid_in            (valid_in),
        .core_ready          (core_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    function automatic rec_t dut_head();
        return {degree_in, x_in, y_in, flip_in, arctan_en_in};
    endfunction

    // Reference conversion in plain integer degrees*256.
    function automatic rec_t ref_conv(input logic [31:0] w, input logic at);
        rec_t r;
        int   d;
        r = '0;
        r.arctan_en = at;
        if (at) begin
            r.x = w[15:0];
            r.y = w[31:16];
        end else begin
            d   = int'($signed(w[15:0]));
            r.x = 16'h0100;
            if (d > 90 * 256) begin
                r.degree = 16'(180 * 256 - d);
                r.flip   = 1'b1;
            end else if (d < -90 * 256) begin
                r.degree = 16'(-180 * 256 - d);
                r.flip   = 1'b1;
            end else begin
                r.degree = 16'(d);
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic at, input logic cr);
        valid_in_interface  = v;
        in_interface        = w;
        arctan_en_interface = at;
        core_ready          = cr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs [11];
    rec_t q [$];
    rec_t last_head;
    rec_t exp_head;
    bit   m_ready;
    bit   exp_valid;
    bit   r_push;
    bit   r_pop;
    logic r_v;
    logic r_at;
    logic r_cr;
    logic [31:0] r_w;

    initial begin
        //                word           at     degree    x         y         flip  at
        vecs[0]  = '{32'h0100_0200, 1'b1, '{16'h0000, 16'h0200, 16'h0100, 1'b0, 1'b1}};
        vecs[1]  = '{32'h1234_F000, 1'b1, '{16'h0000, 16'hF000, 16'h1234, 1'b0, 1'b1}};
        vecs[2]  = '{32'h0000_7800, 1'b0, '{16'h3C00, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[3]  = '{32'h0000_8800, 1'b0, '{16'hC400, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[4]  = '{32'h0000_5A00, 1'b0, '{16'h5A00, 16'h0100, 16'h0000, 1'b0, 1'b0}};
        vecs[5]  = '{32'h0000_A600, 1'b0, '{16'hA600, 16'h0100, 16'h0000, 1'b0, 1'b0}};
        vecs[6]  = '{32'hFFFF_5A01, 1'b0, '{16'h59FF, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[7]  = '{32'h0000_A5FF, 1'b0, '{16'hA601, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[8]  = '{32'h0000_7FFF, 1'b0, '{16'h3401, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[9]  = '{32'h0000_8000, 1'b0, '{16'hCC00, 16'h0100, 16'h0000, 1'b1, 1'b0}};
        vecs[10] = '{32'hABCD_0000, 1'b0, '{16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0}};

        // Reset held for three edges.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_ready", 64'(ready_in_interface), 64'd0);
        check("reset_valid", 64'(valid_in), 64'd0);
        check("reset_operands", 64'(dut_head()), 64'd0);
        rst_n = 1'b1;
        tick();
        check("release_ready", 64'(ready_in_interface), 64'd1);
        check("release_valid", 64'(valid_in), 64'd0);

        // Conversion table: one word each, popped the cycle after it appears.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].word, vecs[i].arctan, 1'b1);
            tick();
            check($sformatf("vec%0d_valid", i), 64'(valid_in), 64'd1);
            check($sformatf("vec%0d_head", i), 64'(dut_head()), 64'(vecs[i].exp));
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            tick();
            check($sformatf("vec%0d_drained", i), 64'({valid_in, ready_in_interface}), 64'b01);
            check($sformatf("vec%0d_hold", i), 64'(dut_head()), 64'(vecs[i].exp));
        end

        // Backpressure: A and B fill the FIFO, C waits on the bus.
        drive(1'b1, 32'h0000_0A0A, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0B0B, 1'b1, 1'b0);
        tick();
        check("bp_full_ready", 64'(ready_in_interface), 64'd0);
        check("bp_head_a", 64'(dut_head()), 64'(ref_conv(32'h0000_0A0A, 1'b1)));
        drive(1'b1, 32'h0000_0C0C, 1'b1, 1'b0);
        tick();
        check("bp_still_full", 64'({valid_in, ready_in_interface}), 64'b10);
        check("bp_head_a_held", 64'(dut_head()), 64'(ref_conv(32'h0000_0A0A, 1'b1)));
        drive(1'b1, 32'h0000_0C0C, 1'b1, 1'b1);
        tick();
        check("bp_head_b", 64'(dut_head()), 64'(ref_conv(32'h0000_0B0B, 1'b1)));
        check("bp_ready_back", 64'(ready_in_interface), 64'd1);
        tick();
        check("bp_head_c", 64'(dut_head()), 64'(ref_conv(32'h0000_0C0C, 1'b1)));
        check("bp_c_valid", 64'(valid_in), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("bp_empty", 64'(valid_in), 64'd0);

        // Simultaneous push and pop with one word buffered.
        drive(1'b1, 32'h0000_7800, 1'b0, 1'b0);
        tick();
        check("pp_head_d", 64'(dut_head()), 64'(ref_conv(32'h0000_7800, 1'b0)));
        drive(1'b1, 32'h0000_8800, 1'b0, 1'b1);
        tick();
        check("pp_ready_valid", 64'({valid_in, ready_in_interface}), 64'b11);
        check("pp_head_e", 64'(dut_head()), 64'(ref_conv(32'h0000_8800, 1'b0)));
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("pp_count_one", 64'(valid_in), 64'd0);

        // Reset with the FIFO full: nothing buffered may survive.
        drive(1'b1, 32'h1111_0001, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h2222_0002, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_state", 64'({valid_in, ready_in_interface}), 64'b00);
        check("mid_rst_operands", 64'(dut_head()), 64'd0);
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h3333_0003, 1'b1, 1'b1);
        tick();
        check("mid_rst_head_h", 64'(dut_head()), 64'(ref_conv(32'h3333_0003, 1'b1)));
        check("mid_rst_valid_h", 64'(valid_in), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        check("mid_rst_only_h", 64'(valid_in), 64'd0);
        tick();
        check("mid_rst_still_empty", 64'(valid_in), 64'd0);

        // Randomized traffic against the queue model, starting from a fresh reset.
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        last_head = '0;
        m_ready   = 1'b0;
        for (int c = 0; c < 500; c++) begin
            exp_valid = (q.size() != 0);
            exp_head  = exp_valid ? q[0] : last_head;
            check($sformatf("rand_c%0d", c),
                  64'({valid_in, ready_in_interface, dut_head()}),
                  64'({exp_valid, m_ready, exp_head}));
            r_v  = 1'($urandom_range(0, 1));
            r_w  = $urandom;
            r_at = 1'($urandom_range(0, 1));
            r_cr = 1'($urandom_range(0, 1));
            drive(r_v, r_w, r_at, r_cr);
            @(posedge clk);
            r_push = r_v && m_ready;
            r_pop  = (q.size() != 0) && r_cr;
            if (r_pop) void'(q.pop_front());
            if (r_push) q.push_back(ref_conv(r_w, r_at));
            if (q.size() != 0) last_head = q[0];
            m_ready = (q.size() < 2);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
